dmem_lsu: RTL

Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a decoded load or store into a word-aligned request on a valid/grant/rvalid data-memory port, with byte enables and lane replication. It returns sign- or zero-extended load data. While an access is in flight it holds the pipeline through `o_stall`, and it flags alignment, width and bus-timeout faults.

---
 rtl/dmem_lsu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit for the 5-stage RV32I pipeline.
//
// Turns a decoded load or store into a word-aligned request on a
// valid/grant/rvalid data-memory port, formats store lanes, extracts and
// extends load data, and holds the pipeline while the access is in flight.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   i_mem_read/write    load / store presented by the EX/MEM register
//   i_funct3            RV32I width/sign encoding
//   i_addr, i_wdata     effective byte address, store data (rs2)
//   o_stall             hold IF..MEM pipeline registers (combinational)
//   o_done              one-cycle completion pulse
//   o_rdata, o_fault    extended load data and fault code, valid with o_done
//                       (fault: 00 none, 01 misaligned, 10 timeout, 11 illegal)
//   o_dmem_*            registered request port (word address, lanes, enables)
//   i_dmem_gnt          request accepted
//   i_dmem_rvalid/rdata read response
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; classify a presented access
// REQ   | request on the bus, waiting for grant
// WAIT  | read granted, waiting for rvalid
// DONE  | o_done pulse with result/fault; pipeline advances at end of cycle

module dmem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_fault,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [2:0]       funct3_q;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic        cnt_last;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    assign access   = i_mem_read | i_mem_write;
    assign cnt_last = (cnt == CNT_LAST);

    assign illegal = (i_mem_read & i_mem_write)
                   | (i_mem_write & (i_funct3 > 3'b010))
                   | (i_mem_read & ((i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11)));

    assign misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0])
                      | ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));

    // A reset mid-access must release the pipeline even while the stalled
    // access is still being presented.
    assign o_stall = ~rst & (((state == IDLE) & access) | (state == REQ) | (state == WAIT));

    // Store lane formatting; reads drive no enables and no data.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        if (i_mem_write) begin
            case (i_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << i_addr[1:0];
                    st_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = i_wdata;
                end
            endcase
        end
    end

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lane_q       <= 2'b00;
            funct3_q     <= 3'b000;
            o_done       <= 1'b0;
            o_rdata      <= 32'h0;
            o_fault      <= 2'b00;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'h0;
            o_dmem_wdata <= 32'h0;
            o_dmem_be    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        lane_q   <= i_addr[1:0];
                        funct3_q <= i_funct3;
                        if (illegal) begin
                            state   <= DONE;
                            o_done  <= 1'b1;
                            o_fault <= 2'b11;
                        end else if (misaligned) begin
                            state   <= DONE;
                            o_done  <= 1'b1;
                            o_fault <= 2'b01;
                        end else begin
                            state        <= REQ;
                            cnt          <= '0;
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= i_mem_write;
                            o_dmem_addr  <= {i_addr[31:2], 2'b00};
                            o_dmem_wdata <= st_wdata;
                            o_dmem_be    <= st_be;
                        end
                    end
                end
                REQ: begin
                    // A write granted on the last budget cycle still completes;
                    // a read granted then could never see rvalid in budget.
                    if (i_dmem_gnt & o_dmem_we) begin
                        state      <= DONE;
                        o_dmem_req <= 1'b0;
                        o_done     <= 1'b1;
                    end else if (cnt_last) begin
                        state      <= DONE;
                        o_dmem_req <= 1'b0;
                        o_done     <= 1'b1;
                        o_fault    <= 2'b10;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (i_dmem_gnt) begin
                            state      <= WAIT;
                            o_dmem_req <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        state   <= DONE;
                        o_done  <= 1'b1;
                        o_rdata <= load_extract(i_dmem_rdata, lane_q, funct3_q);
                    end else if (cnt_last) begin
                        state   <= DONE;
                        o_done  <= 1'b1;
                        o_fault <= 2'b10;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    o_done       <= 1'b0;
                    o_rdata      <= 32'h0;
                    o_fault      <= 2'b00;
                    o_dmem_we    <= 1'b0;
                    o_dmem_addr  <= 32'h0;
                    o_dmem_wdata <= 32'h0;
                    o_dmem_be    <= 4'b0000;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
